sram_dbg_port_ctrl: RTL
=======================

# sram_dbg_port_ctrl

Wishbone-slave controller that sequences debug reads on the second read port (csb1/addr1/rdata1) of the L1 cache SRAM macros: 2 tag-array macros and 4 data_arrays_0_0 macros. It shares that port between Wishbone debug reads and the logic-analyzer override path, with registered ownership so that neither requester can corrupt a read in flight. It sits in the Marmot user-project wrapper beside the cache macros and replaces the direct LA-to-csb1 wiring.

## Interface
Parameters:
- BASE_HI, 16'h3000, required value of wbs_adr_i[31:16] for the block to respond
- RD_LAT, 1, wait cycles after the csb1 issue cycle before rdata1 is captured (1..7)
- TIMEOUT_DEF, 16'd1024, reset value of the TIMEOUT register

Ports:
- clk  in  1  single clock for the block, rising edge
- rst_n  in  1  asynchronous active-low reset
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe, cycle, write-enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i, wbs_dat_i  in  32 each  address, write data
- wbs_ack_o  out  1  one-cycle acknowledge, registered
- wbs_dat_o  out  32  read data, registered, valid while ack=1
- la_sel  in  1  LA requests the port (synchronous to clk)
- la_tag_csb1  in  2, la_data_csb1  in  4, la_addr1  in  9  LA-driven port values
- tag_csb1  out  2, tag_addr1  out  8  tag-macro port 1 (csb active low)
- tag_rdata1_0, tag_rdata1_1  in  32 each
- data_csb1  out  4, data_addr1  out  9  data-macro port 1
- data_rdata1_0 .. data_rdata1_3  in  64 each

## Operation
- Decode (only when wbs_adr_i[31:16]==BASE_HI; otherwise never ack): region = adr[15:14]. 0 tag: macro=adr[2], row=adr[10:3]. 1 data: macro=adr[13:12], row=adr[11:3], half=adr[2] (0 → [31:0], 1 → [63:32]). 2 CSR: offset adr[3:2]. 3 invalid.
- CSR offset 0 STATUS: [15:0] read count (successful SRAM reads, saturates at 0xFFFF), [16] timeout err sticky, [17] decode err sticky, [18] la_sel live. Writing 1 to [16]/[17] clears them (W1C, qualified by sel[2]); [15:0] is cleared by any write with sel[1:0]==2'b11. CSR offset 1 TIMEOUT: [15:0] R/W; 0 = wait forever. Other CSR offsets read 0, writes ignored.
- Writes to region 0/1 and any access to region 3: ack, wbs_dat_o=0, no SRAM activity, set decode err.
- FSM states: IDLE, HOLD, ISSUE, WAIT, ACK.
- IDLE: on stb&cyc with matching base: SRAM read with la_sel=0 → ISSUE; SRAM read with la_sel=1 → HOLD; CSR/invalid → ACK.
- HOLD: the timeout counter increments each cycle. la_sel=0 → ISSUE. Counter reaches a nonzero TIMEOUT → ACK with dat 32'hDEADBEEF and set timeout err. cyc=0 → IDLE without ack.
- ISSUE: set wb_own; drive the selected csb1 bit low and the row on addr1 for exactly one cycle → WAIT.
- WAIT: RD_LAT cycles. In the last cycle capture the selected rdata1 slice → ACK.
- ACK: ack=1 only if cyc=1. Increment count on a successful SRAM read. Clear wb_own → IDLE.
- Port mux: wb_own=1 → Wishbone values. Else la_sel=1 → LA values (tag_addr1=la_addr1[7:0]). Else all csb1 high and addr1 held.
- Once wb_own is set, la_sel is ignored until ACK.

## Timing
- Reset: ack=0, dat_o=0, all csb1=1, addr1=0, STATUS=0, TIMEOUT=TIMEOUT_DEF, state IDLE, wb_own=0.
- An asynchronous reset mid-read aborts immediately; no ack.
- SRAM read with the port free: stb seen in cycle 0, csb1 low in cycle 1, ack in cycle 2+RD_LAT (cycle 3 by default).
- CSR or invalid access: ack in cycle 1.
- Back-to-back requests: at least one IDLE cycle after each ack.
- When an err set and its W1C clear land in the same cycle, the set wins.

## Test plan
- Tag read 0x3000_0014 (macro 1, row 2), tag_rdata1_1=0x0ABCDE12 → tag_csb1=2'b01 and tag_addr1=2 for one cycle; ack in cycle 3; dat=0x0ABCDE12; count=1.
- Data read 0x3000_6014 (macro 2, row 2, upper half), data_rdata1_2=0x1122334455667788 → data_csb1=4'b1011; dat=0x11223344.
- la_sel=1 for 10 cycles during a read with TIMEOUT=100 → LA values drive the port; ISSUE starts the cycle after la_sel falls; read completes normally.
- la_sel held high with TIMEOUT=5 → ack 5 cycles after entering HOLD; dat=0xDEADBEEF; STATUS[16]=1. Then a write 0x10000 to STATUS → STATUS[16]=0.
- la_sel rises in the ISSUE cycle → the Wishbone read completes with correct data; LA gains the port the cycle after ACK.
- Write to 0x3000_0000, then read 0x3000_C000 → both ack in cycle 1 with dat=0; STATUS[17]=1; no csb1 toggles. Assert rst_n low during WAIT → no ack; outputs at reset values.

Source files
------------

// File: rtl/sram_dbg_port_ctrl.sv
// Wishbone debug-read sequencer for port 1 of the L1 tag/data SRAM macros.
// Arbitrates that port between Wishbone debug reads and the logic-analyzer override path.
module sram_dbg_port_ctrl #(
    parameter logic [15:0] BASE_HI     = 16'h3000,
    parameter int          RD_LAT      = 1,
    parameter logic [15:0] TIMEOUT_DEF = 16'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        la_sel,
    input  logic [1:0]  la_tag_csb1,
    input  logic [3:0]  la_data_csb1,
    input  logic [8:0]  la_addr1,
    output logic [1:0]  tag_csb1,
    output logic [7:0]  tag_addr1,
    input  logic [31:0] tag_rdata1_0,
    input  logic [31:0] tag_rdata1_1,
    output logic [3:0]  data_csb1,
    output logic [8:0]  data_addr1,
    input  logic [63:0] data_rdata1_0,
    input  logic [63:0] data_rdata1_1,
    input  logic [63:0] data_rdata1_2,
    input  logic [63:0] data_rdata1_3
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HOLD  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        ACK   = 3'd4
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(RD_LAT - 1);

    state_t      state_r, state_s;
    logic        own_r, ack_r, sram_ok_r, is_data_r, half_r;
    logic        to_err_r, dec_err_r;
    logic [1:0]  macro_r;
    logic [7:0]  tag_row_r, tag_hold_r;
    logic [8:0]  data_row_r, data_hold_r;
    logic [15:0] hold_cnt_r, rd_cnt_r, timeout_r;
    logic [2:0]  wait_cnt_r;
    logic [31:0] dat_r, csr_rdata_s, rd_slice_s;
    logic [63:0] data_word_s;
    logic [15:0] hold_next_s;
    logic        hit_s, accept_s, is_sram_rd_s, is_bad_s, is_csr_s, to_hit_s, wait_last_s;
    logic        status_wr_s, timeout_wr_s;
    logic [1:0]  region_s;
    logic        unused_s;

    assign region_s     = wbs_adr_i[15:14];
    assign hit_s        = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:16] == BASE_HI);
    assign accept_s     = (state_r == IDLE) & hit_s;
    assign is_sram_rd_s = ~region_s[1] & ~wbs_we_i;
    assign is_csr_s     = (region_s == 2'b10);
    assign is_bad_s     = (region_s == 2'b11) | (~region_s[1] & wbs_we_i);
    assign status_wr_s  = accept_s & is_csr_s & wbs_we_i & (wbs_adr_i[3:2] == 2'd0);
    assign timeout_wr_s = accept_s & is_csr_s & wbs_we_i & (wbs_adr_i[3:2] == 2'd1);
    assign hold_next_s  = hold_cnt_r + 16'd1;
    assign to_hit_s     = (timeout_r != 16'd0) && (hold_next_s == timeout_r);
    assign wait_last_s  = (wait_cnt_r == WAIT_LAST);
    assign wbs_ack_o    = ack_r;
    assign wbs_dat_o    = dat_r;
    assign unused_s     = ^{wbs_adr_i[1:0], wbs_dat_i[31:18], wbs_sel_i[3]};

    always_comb begin
        case (wbs_adr_i[3:2])
            2'd0:    csr_rdata_s = {13'd0, la_sel, dec_err_r, to_err_r, rd_cnt_r};
            2'd1:    csr_rdata_s = {16'd0, timeout_r};
            default: csr_rdata_s = 32'd0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // Next-state logic; an abandoned cycle in HOLD drops back without an ack
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (hit_s) begin
                    if (is_sram_rd_s) state_s = la_sel ? HOLD : ISSUE;
                    else              state_s = ACK;
                end else begin
                    state_s = IDLE;
                end
            end
            HOLD: begin
                if (!wbs_cyc_i)    state_s = IDLE;
                else if (!la_sel)  state_s = ISSUE;
                else if (to_hit_s) state_s = ACK;
                else               state_s = HOLD;
            end
            ISSUE:   state_s = WAIT;
            WAIT:    state_s = wait_last_s ? ACK : WAIT;
            ACK:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Port-1 mux: Wishbone owner, then LA override, else idle with address held
    always_comb begin
        if (own_r) begin
            tag_csb1   = ((state_r == ISSUE) && !is_data_r) ? ~(2'b01 << macro_r[0]) : 2'b11;
            data_csb1  = ((state_r == ISSUE) && is_data_r) ? ~(4'b0001 << macro_r) : 4'b1111;
            tag_addr1  = tag_row_r;
            data_addr1 = data_row_r;
        end else if (la_sel) begin
            tag_csb1   = la_tag_csb1;
            data_csb1  = la_data_csb1;
            tag_addr1  = la_addr1[7:0];
            data_addr1 = la_addr1;
        end else begin
            tag_csb1   = 2'b11;
            data_csb1  = 4'b1111;
            tag_addr1  = tag_hold_r;
            data_addr1 = data_hold_r;
        end
    end

    // Selected read-data slice
    always_comb begin
        case (macro_r)
            2'd0:    data_word_s = data_rdata1_0;
            2'd1:    data_word_s = data_rdata1_1;
            2'd2:    data_word_s = data_rdata1_2;
            2'd3:    data_word_s = data_rdata1_3;
            default: data_word_s = 64'd0;
        endcase
        if (is_data_r)      rd_slice_s = half_r ? data_word_s[63:32] : data_word_s[31:0];
        else if (macro_r[0]) rd_slice_s = tag_rdata1_1;
        else                rd_slice_s = tag_rdata1_0;
    end

    // Request capture, ownership, counters and the registered Wishbone response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_r <= 1'b0;  is_data_r <= 1'b0;  half_r <= 1'b0;  macro_r <= 2'd0;
            tag_row_r <= 8'd0;  data_row_r <= 9'd0;
            tag_hold_r <= 8'd0; data_hold_r <= 9'd0;
            hold_cnt_r <= 16'd0; wait_cnt_r <= 3'd0; sram_ok_r <= 1'b0;
            ack_r <= 1'b0;  dat_r <= 32'd0;
        end else begin
            if (state_r == ACK)        own_r <= 1'b0;
            else if (state_s == ISSUE) own_r <= 1'b1;
            if (accept_s && is_sram_rd_s) begin
                is_data_r  <= region_s[0];
                macro_r    <= region_s[0] ? wbs_adr_i[13:12] : {1'b0, wbs_adr_i[2]};
                half_r     <= wbs_adr_i[2];
                tag_row_r  <= wbs_adr_i[10:3];
                data_row_r <= wbs_adr_i[11:3];
            end
            tag_hold_r  <= tag_addr1;
            data_hold_r <= data_addr1;
            hold_cnt_r  <= (state_r == HOLD) ? hold_next_s : 16'd0;
            wait_cnt_r  <= (state_r == WAIT) ? (wait_cnt_r + 3'd1) : 3'd0;
            sram_ok_r   <= (state_r == WAIT) && wait_last_s;
            ack_r       <= (state_s == ACK) && wbs_cyc_i;
            if (state_s == ACK) begin
                case (state_r)
                    IDLE:    dat_r <= (is_csr_s && !wbs_we_i) ? csr_rdata_s : 32'd0;
                    HOLD:    dat_r <= 32'hDEADBEEF;
                    WAIT:    dat_r <= rd_slice_s;
                    default: dat_r <= 32'd0;
                endcase
            end else begin
                dat_r <= 32'd0;
            end
        end
    end

    // STATUS / TIMEOUT registers; a sticky set outranks a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_err_r  <= 1'b0;
            dec_err_r <= 1'b0;
            rd_cnt_r  <= 16'd0;
            timeout_r <= TIMEOUT_DEF;
        end else begin
            if ((state_r == HOLD) && (state_s == ACK))             to_err_r <= 1'b1;
            else if (status_wr_s && wbs_sel_i[2] && wbs_dat_i[16]) to_err_r <= 1'b0;
            if (accept_s && is_bad_s)                              dec_err_r <= 1'b1;
            else if (status_wr_s && wbs_sel_i[2] && wbs_dat_i[17]) dec_err_r <= 1'b0;
            if (status_wr_s && (wbs_sel_i[1:0] == 2'b11))         rd_cnt_r <= 16'd0;
            else if (ack_r && sram_ok_r && (rd_cnt_r != 16'hFFFF)) rd_cnt_r <= rd_cnt_r + 16'd1;
            if (timeout_wr_s && wbs_sel_i[0]) timeout_r[7:0]  <= wbs_dat_i[7:0];
            if (timeout_wr_s && wbs_sel_i[1]) timeout_r[15:8] <= wbs_dat_i[15:8];
        end
    end

endmodule
